// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and width helpers.
package fifo_wr_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Widths for the default configuration (NUM_SRC=4, MAX_BURST=8)
    localparam int SRC_W  = $clog2(4);
    localparam int BEAT_W = $clog2(8) + 1;

    function automatic int src_w(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    function automatic int beat_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search: first set request strictly after rr_ptr_i, wrapping.
module rr_picker
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = src_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic               found_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic [NUM_SRC-1:0] rot;
    logic [NUM_SRC-1:0] first_oh;
    logic [PTR_W-1:0]   pos_idx [NUM_SRC];

    // rot[j] is the request of source (rr_ptr+1+j) mod NUM_SRC
    always_comb begin
        rot = NUM_SRC'({req_i, req_i} >> (32'(rr_ptr_i) + 32'd1));
    end

    assign first_oh = rot & (~rot + NUM_SRC'(1));
    assign found_o  = |req_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_pos
            assign pos_idx[gi] = first_oh[gi]
                ? PTR_W'((32'(rr_ptr_i) + 32'(gi) + 32'd1) % NUM_SRC)
                : '0;
        end
    endgenerate

    always_comb begin
        idx_o = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            idx_o = idx_o | pos_idx[j];
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_SRC burst requesters.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          req,
    input  logic [NUM_SRC*WIDTH-1:0]    data,
    input  logic [NUM_SRC-1:0]          last,
    output logic [NUM_SRC-1:0]          ack,
    input  logic                        wfull,
    output logic                        winc,
    output logic [WIDTH-1:0]            wdata,
    output logic                        grant_valid,
    output logic [src_w(NUM_SRC)-1:0]   grant_id,
    output logic [CNT_W-1:0]            total_cnt
);

    localparam int GW = src_w(NUM_SRC);
    localparam int BW = beat_w(MAX_BURST);

    logic [0:0]       state_q, state_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]    grant_id_q, grant_id_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] total_cnt_q, total_cnt_d;

    logic [WIDTH-1:0] data_arr [NUM_SRC];
    logic             pick_found;
    logic [GW-1:0]    pick_idx;
    logic             req_g, last_g, xfer;

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (GW)
    ) u_rr_picker (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign data_arr[gi] = data[gi*WIDTH +: WIDTH];
            assign ack[gi]      = xfer && (grant_id_q == GW'(gi));
        end
    endgenerate

    assign req_g  = req[grant_id_q];
    assign last_g = last[grant_id_q];
    // Gated by rst_n so an aborted burst never writes in the reset cycle
    assign xfer   = rst_n && (state_q == ST_BURST) && req_g && !wfull;

    assign winc        = xfer;
    assign wdata       = xfer ? data_arr[grant_id_q] : '0;
    assign grant_valid = rst_n && (state_q == ST_BURST);
    assign grant_id    = grant_id_q;
    assign total_cnt   = total_cnt_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        total_cnt_d = total_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    beat_cnt_d  = beat_cnt_q + BW'(1);
                    total_cnt_d = total_cnt_q + CNT_W'(1);
                end
                if (!req_g || (xfer && (last_g || beat_cnt_q == BW'(MAX_BURST - 1)))) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_id_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= GW'(NUM_SRC - 1);
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            total_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            total_cnt_q <= total_cnt_d;
        end
    end

endmodule
